// File: rtl/spi_burst_memory.sv
// SPI mode-0 slave fronting a 2**ADDR_W x DATA_W register file: command word, then data words.
// Define SPI_BURST_MEMORY_BURST_EN for auto-incrementing multi-word transfers within one cs window.
module spi_burst_memory #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_pin,
    input  logic       cs_pin,
    input  logic       mosi_pin,
    output logic       miso_pin,
    output logic       miso_oe,
    output logic [3:0] leds
);

`ifdef SPI_BURST_MEMORY_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    localparam int SH_W  = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int MAX_N = ((ADDR_W + 1) > DATA_W) ? (ADDR_W + 1) : DATA_W;
    localparam int CNT_W = $clog2(MAX_N + 1);

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        WRITE,
        READ,
        DONE
    } state_t;

    state_t state, next_state;

    logic [1:0]        sclk_sync, cs_sync, mosi_sync;
    logic              sclk_d;
    logic              sclk_s, cs_s, mosi_s;
    logic              rise, fall;
    logic              cmd_last, wr_last, rd_last;

    logic [CNT_W-1:0]  bit_cnt;
    logic [SH_W-1:0]   in_shift;
    logic [DATA_W-1:0] out_shift;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] addr;
    logic              commit_pending;
    logic              load_pending;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // cs synchronises to "deselected" so a reset never looks like a transaction start.
    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk_pin};
            cs_sync   <= {cs_sync[0], cs_pin};
            mosi_sync <= {mosi_sync[0], mosi_pin};
            sclk_d    <= sclk_sync[1];
        end
    end

    assign sclk_s = sclk_sync[1];
    assign cs_s   = cs_sync[1];
    assign mosi_s = mosi_sync[1];

    // Edges coinciding with a deselect are dropped.
    assign rise = sclk_s & ~sclk_d & ~cs_s;
    assign fall = ~sclk_s & sclk_d & ~cs_s;

    assign cmd_last = (state == CMD)   && rise && (bit_cnt == CNT_W'(ADDR_W));
    assign wr_last  = (state == WRITE) && rise && (bit_cnt == CNT_W'(DATA_W - 1));
    assign rd_last  = (state == READ)  && fall && (bit_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (!cs_s) next_state = CMD;
            CMD:     if (cmd_last) next_state = mosi_s ? READ : WRITE;
            WRITE:   if (wr_last) next_state = BURST ? WRITE : DONE;
            READ:    if (rd_last) next_state = BURST ? READ : DONE;
            DONE:    next_state = DONE;
            default: next_state = IDLE;
        endcase
        if (cs_s) next_state = IDLE;
    end

    // Commit and load happen one cycle after the triggering strobe; a deselect
    // in that cycle still lets a completed word land but drops the output enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt        <= '0;
            in_shift       <= '0;
            out_shift      <= '0;
            wr_data        <= '0;
            addr           <= '0;
            commit_pending <= 1'b0;
            load_pending   <= 1'b0;
            miso_pin       <= 1'b0;
            miso_oe        <= 1'b0;
            leds           <= 4'h0;
        end else begin
            commit_pending <= 1'b0;
            load_pending   <= 1'b0;

            if (commit_pending) begin
                leds <= wr_data[3:0];
                if (BURST) addr <= addr + ADDR_W'(1);
            end

            if (load_pending) begin
                out_shift <= mem[addr];
                miso_oe   <= 1'b1;
            end

            if (cs_s) begin
                bit_cnt <= '0;
                miso_oe <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        bit_cnt  <= '0;
                        in_shift <= '0;
                    end
                    CMD: begin
                        if (rise) begin
                            in_shift <= {in_shift[SH_W-2:0], mosi_s};
                            if (cmd_last) begin
                                addr         <= in_shift[ADDR_W-1:0];
                                bit_cnt      <= '0;
                                load_pending <= mosi_s;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    WRITE: begin
                        if (rise) begin
                            in_shift <= {in_shift[SH_W-2:0], mosi_s};
                            if (wr_last) begin
                                wr_data        <= {in_shift[DATA_W-2:0], mosi_s};
                                commit_pending <= 1'b1;
                                bit_cnt        <= '0;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    READ: begin
                        if (fall) begin
                            miso_pin  <= out_shift[DATA_W-1];
                            out_shift <= {out_shift[DATA_W-2:0], 1'b0};
                            if (rd_last) begin
                                bit_cnt <= '0;
                                if (BURST) begin
                                    addr         <= addr + ADDR_W'(1);
                                    load_pending <= 1'b1;
                                end else begin
                                    miso_oe <= 1'b0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DONE: begin
                        miso_oe <= 1'b0;
                    end
                    default: begin
                        bit_cnt <= '0;
                    end
                endcase
            end
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && commit_pending) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_spi_burst_memory.sv
// Self-checking bench for spi_burst_memory: bit-banged SPI master against an array-based memory model.
// Honours SPI_BURST_MEMORY_BURST_EN to select the burst or single-word expectations.
module tb_spi_burst_memory;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int HALF   = 6;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sclk_pin = 1'b0;
    logic       cs_pin = 1'b1;
    logic       mosi_pin = 1'b0;
    logic       miso_pin;
    logic       miso_oe;
    logic [3:0] leds;

    int checks = 0;
    int failures = 0;

    logic [7:0] model_mem [DEPTH];
    logic [3:0] model_leds;
    logic [7:0] tx_words [4];
    logic [7:0] rx_words [4];
    logic       oe_first;

    spi_burst_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .sclk_pin (sclk_pin),
        .cs_pin   (cs_pin),
        .mosi_pin (mosi_pin),
        .miso_pin (miso_pin),
        .miso_oe  (miso_oe),
        .leds     (leds)
    );

    always #5 clk = ~clk;

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCLK period: mosi set during low phase, miso sampled at the rising edge.
    task automatic spi_bit(input logic b, output logic sampled, output logic oe);
        mosi_pin = b;
        wait_clks(HALF);
        sclk_pin = 1'b1;
        sampled  = miso_pin;
        oe       = miso_oe;
        wait_clks(HALF);
        sclk_pin = 1'b0;
    endtask

    task automatic spi_txn(input logic [6:0] a, input logic rw, input int nwords, input int tail_bits);
        logic s, o;
        cs_pin = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < ADDR_W; i++) spi_bit(a[6-i], s, o);
        spi_bit(rw, s, o);
        for (int w = 0; w < nwords; w++) begin
            for (int b = 0; b < DATA_W; b++) begin
                spi_bit(tx_words[w][7-b], s, o);
                rx_words[w][7-b] = s;
                if (w == 0 && b == 0) oe_first = o;
            end
        end
        for (int b = 0; b < tail_bits; b++) spi_bit(tx_words[nwords][7-b], s, o);
        wait_clks(HALF);
        cs_pin = 1'b1;
        wait_clks(HALF + 2);
    endtask

    // Reference behaviour of a completed write transaction of nwords words.
    task automatic model_write(input int a, input int nwords);
        int n;
`ifdef SPI_BURST_MEMORY_BURST_EN
        n = nwords;
`else
        n = (nwords > 0) ? 1 : 0;
`endif
        for (int i = 0; i < n; i++) begin
            model_mem[(a + i) % DEPTH] = tx_words[i];
            model_leds = tx_words[i][3:0];
        end
    endtask

    task automatic write_word(input logic [6:0] a, input logic [7:0] d);
        tx_words[0] = d;
        spi_txn(a, 1'b0, 1, 0);
        model_write(int'(a), 1);
    endtask

    task automatic read_check(input logic [6:0] a, input string name);
        spi_txn(a, 1'b1, 1, 0);
        checks++;
        if (rx_words[0] !== model_mem[a]) begin
            failures++;
            $display("[TB] FAIL %s addr %h: got %h expected %h", name, a, rx_words[0], model_mem[a]);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        wait_clks(3);
        checks++;
        if ({miso_oe, miso_pin, leds} !== 6'b0) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got oe=%b miso=%b leds=%h expected all zero", miso_oe, miso_pin, leds);
        end
        reset = 1'b0;
        model_leds = 4'h0;
        wait_clks(6);
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL reset_leds: got %h expected %h", leds, model_leds);
        end
    endtask

    task automatic test_write_read();
        write_word(7'h00, 8'hFF);
        read_check(7'h00, "write_read_data");
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL write_read_leds: got %h expected %h", leds, model_leds);
        end
        checks++;
        if (oe_first !== 1'b1) begin
            failures++;
            $display("[TB] FAIL read_oe: got %b expected 1", oe_first);
        end
    endtask

    task automatic test_random();
        logic [6:0] addrs [8];
        for (int i = 0; i < 8; i++) begin
            addrs[i] = 7'($urandom_range(DEPTH - 1, 0));
            write_word(addrs[i], 8'($urandom));
            checks++;
            if (leds !== model_leds) begin
                failures++;
                $display("[TB] FAIL random_leds: got %h expected %h", leds, model_leds);
            end
        end
        for (int i = 0; i < 8; i++) read_check(addrs[i], "random_read");
    endtask

    task automatic test_abort();
        write_word(7'h05, 8'h3C);
        tx_words[0] = 8'hA0;
        spi_txn(7'h05, 1'b0, 0, 4);
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL abort_leds: got %h expected %h", leds, model_leds);
        end
        read_check(7'h05, "abort_mem");
    endtask

`ifdef SPI_BURST_MEMORY_BURST_EN
    task automatic test_burst();
        int a;
        tx_words[0] = 8'h11;
        tx_words[1] = 8'h22;
        spi_txn(7'h7F, 1'b0, 2, 0);
        model_write(127, 2);
        spi_txn(7'h7F, 1'b1, 2, 0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (rx_words[i] !== model_mem[(127 + i) % DEPTH]) begin
                failures++;
                $display("[TB] FAIL burst_wrap_word%0d: got %h expected %h", i, rx_words[i], model_mem[(127 + i) % DEPTH]);
            end
        end
        read_check(7'h00, "burst_wrap_mem0");
        a = $urandom_range(DEPTH - 1, 0);
        for (int i = 0; i < 3; i++) tx_words[i] = 8'($urandom);
        spi_txn(7'(a), 1'b0, 3, 0);
        model_write(a, 3);
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL burst_leds: got %h expected %h", leds, model_leds);
        end
        spi_txn(7'(a), 1'b1, 3, 0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_words[i] !== model_mem[(a + i) % DEPTH]) begin
                failures++;
                $display("[TB] FAIL burst_random_word%0d: got %h expected %h", i, rx_words[i], model_mem[(a + i) % DEPTH]);
            end
        end
    endtask
`else
    task automatic test_single_word();
        write_word(7'h04, 8'h96);
        tx_words[0] = 8'h5A;
        tx_words[1] = 8'hC3;
        spi_txn(7'h03, 1'b0, 2, 0);
        model_write(3, 2);
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL single_leds: got %h expected %h", leds, model_leds);
        end
        read_check(7'h03, "single_addr3");
        read_check(7'h04, "single_addr4");
    endtask
`endif

    task automatic test_reset_mid_read();
        logic s, o;
        write_word(7'h40, 8'hE7);
        cs_pin = 1'b0;
        wait_clks(HALF);
        for (int i = 0; i < ADDR_W; i++) spi_bit(((7'h40 >> (6 - i)) & 7'h1) != 0, s, o);
        spi_bit(1'b1, s, o);
        for (int b = 0; b < 3; b++) spi_bit(1'b0, s, o);
        wait_clks(HALF);
        reset = 1'b1;
        wait_clks(1);
        reset = 1'b0;
        model_leds = 4'h0;
        checks++;
        if ({miso_oe, miso_pin} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_mid_read_miso: got oe=%b miso=%b expected 0 0", miso_oe, miso_pin);
        end
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL reset_mid_read_leds: got %h expected %h", leds, model_leds);
        end
        cs_pin = 1'b1;
        wait_clks(HALF + 2);
        read_check(7'h40, "reset_retained");
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL reset_leds_after_read: got %h expected %h", leds, model_leds);
        end
        write_word(7'h41, 8'h5B);
        read_check(7'h41, "reset_then_write");
        checks++;
        if (leds !== model_leds) begin
            failures++;
            $display("[TB] FAIL reset_then_write_leds: got %h expected %h", leds, model_leds);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
        model_leds = 4'h0;
        oe_first   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tx_words[i] = 8'h00;
            rx_words[i] = 8'h00;
        end
        test_reset();
        test_write_read();
        test_random();
        test_abort();
`ifdef SPI_BURST_MEMORY_BURST_EN
        test_burst();
`else
        test_single_word();
`endif
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_burst_memory.md
# spi_burst_memory

Parametrised SPI-slave memory, successor to the fixed 7-bit-address / 8-bit-data SPI memory. An external SPI master issues a command word (address plus read/write bit) followed by one or more data words; the block stores or returns words from an internal register array. All SPI pins are asynchronous to `clk` and are synchronised into the `clk` domain. Optional burst mode auto-increments the address for multi-word transfers within one chip-select window.

## Interface
- `ADDR_W`, default 7: address width; memory depth = 2**ADDR_W words.
- `DATA_W`, default 8: word width, minimum 4.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sclk_pin`  in  1  SPI clock from master, asynchronous.
- `cs_pin`  in  1  chip select, active low, asynchronous.
- `mosi_pin`  in  1  master-out data, asynchronous.
- `miso_pin`  out  1  slave-out data.
- `miso_oe`  out  1  high while `miso_pin` carries valid read data.
- `leds`  out  4  low 4 bits of the most recently committed write word.

## Operation
- Input synchronisation: `sclk_pin`, `cs_pin` and `mosi_pin` each pass through a 2-flop synchroniser. Rise/fall strobes come from the synchronised sclk and a 1-flop delayed copy.
- Protocol (SPI mode 0, MSB first):
  - MOSI is sampled on sclk rise; MISO is updated on sclk fall.
  - Command word = ADDR_W address bits, then 1 R/W bit (1 = read, 0 = write).
- FSM states: IDLE, CMD, WRITE, READ, DONE.
- IDLE -> CMD: synchronised cs low. Clears the bit counter and shift register.
- CMD: shifts in ADDR_W+1 bits.
  - On the final rise, the address register loads.
  - R/W=0 -> WRITE.
  - R/W=1 -> READ. In the clk cycle after the final rise, the output shift register loads `mem[addr]` and `miso_oe` asserts.
- WRITE: shifts DATA_W bits. On the final rise:
  - `mem[addr]` is written on the next clk edge.
  - `leds` takes `data[3:0]` on that same edge.
  - Then -> DONE, or re-arms WRITE (see Configuration).
- READ:
  - Each sclk fall shifts the output register; `miso_pin` = MSB.
  - The first data bit is driven on the first fall after the command, with no dummy cycle.
  - After DATA_W falls: -> DONE, or reload (see Configuration).
- DONE: ignores sclk and mosi; `miso_oe`=0.
- Any state, synchronised cs high -> IDLE in the next clk cycle.
  - A partially shifted write word is discarded; no memory write occurs.
  - `miso_oe` deasserts.
- `reset`:
  - FSM -> IDLE; counters and shift registers cleared.
  - `miso_pin`=0, `miso_oe`=0, `leds`=0.
  - Memory contents are not cleared.
- Address arithmetic is modulo 2**ADDR_W.
- When cs rises, sclk edges detected in the same synchronised cycle are ignored.

## Timing
- Pin-to-internal latency: 3 clk cycles (2 synchroniser + 1 edge detect).
- Master constraints:
  - sclk high ≥ 4 clk cycles and sclk low ≥ 4 clk cycles.
  - cs fall to first sclk rise ≥ 4 clk cycles.
  - cs rise after the last sclk rise ≥ 4 clk cycles.
- Write commit: 1 clk cycle after the strobe of the final data rise.
- Read load: 1 clk cycle after the strobe of the final command rise. This guarantees the data is ready before the next sclk fall under the constraints above.
- `miso_pin` changes 1 clk cycle after the internal fall strobe, then stays stable through the next rise.
- Reset takes priority over all other events in the same cycle.

## Configuration
- Macro `SPI_BURST_MEMORY_BURST_EN`.
- Defined (burst mode):
  - After each complete data word, `addr` ← `addr`+1 (wrapping) and the FSM stays in WRITE/READ.
  - In READ, the next word loads in the cycle after the last bit's fall strobe, so the stream is continuous.
  - The transfer ends only when cs rises.
- Undefined (single-word mode):
  - Exactly one data word per cs window; the FSM then enters DONE.
  - Extra sclk edges before cs rises have no effect on memory, `leds` or `miso_oe`.

## Test plan
- Write then read (ADDR_W=7, DATA_W=8):
  - Command 0x00 (addr 0, W), then data 0xFF; cs high.
  - Command 0x01 (addr 0, R), then 8 clocks -> MISO reads 11111111, `leds`=0xF.
- Abort mid-write:
  - Command write addr 5, 4 data bits of 0xA0, then cs high.
  - Read addr 5 -> prior contents unchanged; `leds` unchanged.
- Burst wrap (macro defined):
  - Write addr 0x7F with 0x11, 0x22 in one cs window.
  - Read addr 0x7F for 2 words -> 0x11 then 0x22; `mem[0]` = 0x22.
- Single-word mode (macro undefined):
  - Write addr 3 with 0x5A, then 8 more bits 0xC3 before cs high.
  - Reads -> addr 3 = 0x5A; addr 4 unchanged.
- Reset mid-read:
  - Assert `reset` for 1 clk during a READ data bit.
  - -> `miso_oe`=0, `miso_pin`=0, `leds`=0, FSM idle.
  - Next full transaction behaves normally; memory is retained.
